arb_mux_reg: RTL and testbench

Parametrised, registered N-channel multiplexer with valid/ready handshaking on every input and on the output. It is the successor to the fixed 1-bit 4:1 combinational mux and selects one of NCH channels of WIDTH bits each. Selection is either static (a `sel` input, as in the classic mux) or round-robin arbitration among valid channels. It sits between multiple producers and a single consumer in a streaming datapath and provides one cycle of registered latency at full throughput.

---
 rtl/arb_mux_pkg.sv | 10 +
 rtl/arb_mux_reg_rr_arbiter.sv | 45 ++++
 rtl/arb_mux_reg.sv | 124 ++++++++++++
 tb/tb_arb_mux_reg.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the registered arbitrating multiplexer.
// The mode input is compared against these encodings.
package arb_mux_pkg;

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

endpackage

// File: rtl/arb_mux_reg_rr_arbiter.sv
// Combinational rotate-priority arbiter: the first requester at or after ptr wins.
// ptr is expected to be below NCH; the wrap is a single subtraction so any NCH works.
module rr_arbiter #(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] gnt_idx
);

    localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

    logic [SELW:0] cand_s;
    logic          found_s;

    // Scan NCH candidates starting at ptr, wrapping modulo NCH.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < NCH; k++) begin
            cand_s = {1'b0, ptr} + (SELW+1)'(k);
            if (cand_s >= NCH_W) begin
                cand_s = cand_s - NCH_W;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s[SELW-1:0]]) begin
                found_s = 1'b1;
                gnt_idx = cand_s[SELW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            gnt[gnt_idx] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/arb_mux_reg.sv
// Registered N-channel mux with valid/ready on every port; static select or
// round-robin arbitration, one cycle latency at full throughput.
module arb_mux_reg
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

    logic [SELW-1:0]  ptr_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_ch_r;
    logic             out_valid_r;

    logic             load_s;
    logic             req_s;
    logic             xfer_s;
    logic [SELW-1:0]  grant_s;
    logic [SELW-1:0]  next_ptr_s;
    logic [WIDTH-1:0] data_s;
    logic [NCH-1:0]   rr_gnt_s;
    logic [SELW-1:0]  rr_idx_s;
    logic [NCH-1:0]   in_ready_s;

    rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (ptr_r),
        .gnt     (rr_gnt_s),
        .gnt_idx (rr_idx_s)
    );

    assign load_s = !out_valid_r || out_ready;

    // Grant selection: out-of-range static indices never form a request.
    always_comb begin
        grant_s = sel;
        req_s   = 1'b0;
        if (mode == MODE_RR) begin
            grant_s = rr_idx_s;
            req_s   = |in_valid;
        end else if ({1'b0, sel} < NCH_W) begin
            grant_s = sel;
            req_s   = in_valid[sel];
        end else begin
            grant_s = sel;
            req_s   = 1'b0;
        end
    end

    // Ready generation and selected-data mux.
    always_comb begin
        in_ready_s = '0;
        data_s     = '0;
        if (rst_n && load_s && req_s) begin
            if (mode == MODE_RR) begin
                in_ready_s = rr_gnt_s;
            end else begin
                in_ready_s[grant_s] = 1'b1;
            end
        end else begin
            in_ready_s = '0;
        end
        for (int i = 0; i < NCH; i++) begin
            if (grant_s == SELW'(i)) begin
                data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                data_s = data_s;
            end
        end
        if (grant_s == SELW'(NCH-1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_s + SELW'(1);
        end
    end

    assign xfer_s = load_s && req_s;

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
            ptr_r       <= '0;
        end else begin
            if (xfer_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= data_s;
                out_ch_r    <= grant_s;
            end else if (load_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (xfer_s && (mode == MODE_RR)) begin
                ptr_r <= next_ptr_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Scoreboard bench for arb_mux_reg: a 4-channel and a 3-channel instance,
// directed vectors with hand-computed grants and words.
module tb_arb_mux_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 4-channel instance
    logic        mode, out_ready, out_valid;
    logic [1:0]  sel, out_ch;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [7:0]  out_data;

    arb_mux_reg #(.WIDTH(8), .NCH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // 3-channel instance
    logic        mode3, out_ready3, out_valid3;
    logic [1:0]  sel3, out_ch3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [7:0]  out_data3;

    arb_mux_reg #(.WIDTH(8), .NCH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    logic [9:0] exp_q4[$];
    logic [9:0] exp_q3[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a word is consumed on the edge following a negedge where valid && ready.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q4.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL mon4_unexpected: got %0h/%0d, expected nothing", out_data, out_ch);
            end else begin
                chk("mon4_word", {out_data, out_ch}, exp_q4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid3 === 1'b1 && out_ready3 === 1'b1) begin
            if (exp_q3.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL mon3_unexpected: got %0h/%0d, expected nothing", out_data3, out_ch3);
            end else begin
                chk("mon3_word", {out_data3, out_ch3}, exp_q3.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on dut4: check in_ready, optionally queue the expected word and check output regs.
    task automatic step4(input logic [3:0] exp_rdy, input logic push, input logic [7:0] ed,
                         input logic [1:0] ec, input logic chk_out, input logic exp_ov,
                         input logic [7:0] exp_od);
        @(negedge clk);
        chk("in_ready4", in_ready, exp_rdy);
        if (push) exp_q4.push_back({ed, ec});
        if (chk_out) begin
            chk("out_valid4", out_valid, exp_ov);
            if (exp_ov) chk("out_data4", out_data, exp_od);
        end
        tick();
    endtask

    task automatic step3(input logic [2:0] exp_rdy, input logic push, input logic [7:0] ed,
                         input logic [1:0] ec, input logic chk_out, input logic exp_ov);
        @(negedge clk);
        chk("in_ready3", in_ready3, exp_rdy);
        if (push) exp_q3.push_back({ed, ec});
        if (chk_out) chk("out_valid3", out_valid3, exp_ov);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid = 4'b1111;
        mode3 = 1'b1; sel3 = 2'd0; out_ready3 = 1'b1;
        in_data3 = {8'hC3, 8'hB2, 8'hA1};
        in_valid3 = 3'b111;

        // Reset with all channels valid
        @(negedge clk);
        chk("rst_in_ready4", in_ready, 4'b0000);
        chk("rst_in_ready3", in_ready3, 3'b000);
        tick();
        @(negedge clk);
        chk("rst_in_ready4b", in_ready, 4'b0000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_ch", out_ch, 2'd0);
        chk("rst_out_valid3", out_valid3, 1'b0);
        tick();
        rst_n = 1'b1;
        in_valid3 = 3'b000;

        // Static select, channel 2, full throughput
        for (int i = 0; i < 3; i++) step4(4'b0100, 1'b1, 8'h33, 2'd2, 1'b0, 1'b0, 8'h00);
        sel = 2'd0;
        step4(4'b0001, 1'b1, 8'h11, 2'd0, 1'b0, 1'b0, 8'h00);
        sel = 2'd1; in_valid = 4'b0001;
        step4(4'b0000, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 8'h11);
        step4(4'b0000, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00);

        // Round-robin fairness, all valid (ptr starts at 0)
        mode = 1'b1; in_valid = 4'b1111;
        step4(4'b0001, 1'b1, 8'h11, 2'd0, 1'b0, 1'b0, 8'h00);
        step4(4'b0010, 1'b1, 8'h22, 2'd1, 1'b0, 1'b0, 8'h00);
        step4(4'b0100, 1'b1, 8'h33, 2'd2, 1'b0, 1'b0, 8'h00);
        step4(4'b1000, 1'b1, 8'h44, 2'd3, 1'b0, 1'b0, 8'h00);
        step4(4'b0001, 1'b1, 8'h11, 2'd0, 1'b0, 1'b0, 8'h00);
        step4(4'b0010, 1'b1, 8'h22, 2'd1, 1'b0, 1'b0, 8'h00);
        step4(4'b0100, 1'b1, 8'h33, 2'd2, 1'b0, 1'b0, 8'h00);

        // Skip and wrap: ptr=3, only channels 1 and 3 valid
        in_valid = 4'b1010;
        step4(4'b1000, 1'b1, 8'h44, 2'd3, 1'b0, 1'b0, 8'h00);
        step4(4'b0010, 1'b1, 8'h22, 2'd1, 1'b0, 1'b0, 8'h00);
        step4(4'b1000, 1'b1, 8'h44, 2'd3, 1'b0, 1'b0, 8'h00);

        // Backpressure: load A5, stall 3 cycles, then drain and load with no bubble
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
        in_data = {8'h44, 8'h33, 8'h22, 8'hA5};
        step4(4'b0001, 1'b1, 8'hA5, 2'd0, 1'b0, 1'b0, 8'h00);
        out_ready = 1'b0;
        in_data = {8'h44, 8'h33, 8'h22, 8'h5A};
        for (int i = 0; i < 3; i++) step4(4'b0000, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 8'hA5);
        out_ready = 1'b1;
        step4(4'b0001, 1'b1, 8'h5A, 2'd0, 1'b1, 1'b1, 8'hA5);
        in_valid = 4'b0000;
        step4(4'b0000, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 8'h5A);
        step4(4'b0000, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00);

        // Non-power-of-2 channel count, round-robin then out-of-range static select
        in_valid3 = 3'b111;
        step3(3'b001, 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0);
        step3(3'b010, 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0);
        step3(3'b100, 1'b1, 8'hC3, 2'd2, 1'b0, 1'b0);
        step3(3'b001, 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0);
        mode3 = 1'b0; sel3 = 2'd3;
        step3(3'b000, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1);
        step3(3'b000, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0);

        tick();
        chk("queue4_drained", exp_q4.size(), 0);
        chk("queue3_drained", exp_q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
